// File: rtl/totp_pkg.sv
// totp_pkg: shared types and constants for the authenticator code sequencer.
//   totp_state_t   - sequencer FSM states (also exported on the debug port)
//   DIGEST_W       - SHA-1 digest width
//   MSG_W          - HMAC message width (64-bit step count T)
//   TRUNC_W        - width of the dynamically truncated value P
//   BCD_DIGITS_MAX - digits needed to hold any 31-bit value in BCD
//   CONV_CYCLES    - double-dabble iterations for a TRUNC_W-bit input
package totp_pkg;

   localparam int DIGEST_W       = 160;
   localparam int MSG_W          = 64;
   localparam int TRUNC_W        = 31;
   localparam int BCD_DIGITS_MAX = 10;
   localparam int CONV_CYCLES    = 31;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_HASH  = 3'd2,
      ST_TRUNC = 3'd3,
      ST_CONV  = 3'd4,
      ST_DONE  = 3'd5
   } totp_state_t;

endpackage

// File: rtl/bin2bcd_serial.sv
// bin2bcd_serial: serial double-dabble converter, one shift per clock.
//   clk, rst - clock, synchronous active-high reset
//   load     - capture bin and start a conversion
//   bin      - TRUNC_W-bit binary input
//   bcd      - BCD_DIGITS_MAX packed BCD digits, digit 0 in bits [3:0]
//   done     - high once all CONV_CYCLES shifts are complete; stays high
//              until the next load
module bin2bcd_serial
   import totp_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          load,
   input  logic [TRUNC_W-1:0]            bin,
   output logic [4*BCD_DIGITS_MAX-1:0]   bcd,
   output logic                          done
);

   localparam int BCD_W = 4*BCD_DIGITS_MAX;
   localparam int SH_W  = BCD_W + TRUNC_W;
   localparam logic [4:0] LAST_CNT = 5'(CONV_CYCLES);

   // {bcd digits, remaining binary bits}
   logic [SH_W-1:0] shift_q, shift_d;
   // number of shifts performed so far; 0 means idle
   logic [4:0]      cnt_q, cnt_d;
   logic [SH_W-1:0] adj;

   always_comb begin
      adj = shift_q;
      for (int d = 0; d < BCD_DIGITS_MAX; d++) begin
         if (adj[TRUNC_W+4*d +: 4] >= 4'd5) begin
            adj[TRUNC_W+4*d +: 4] = adj[TRUNC_W+4*d +: 4] + 4'd3;
         end
      end

      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (load) begin
         // The first iteration is folded into the load: with all BCD digits
         // still zero no add-3 correction can apply, so it is a plain shift.
         shift_d = {{BCD_W{1'b0}}, bin} << 1;
         cnt_d   = 5'd1;
      end else if (cnt_q != 5'd0 && cnt_q != LAST_CNT) begin
         shift_d = adj << 1;
         cnt_d   = cnt_q + 5'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bcd  = shift_q[SH_W-1 -: BCD_W];
   assign done = (cnt_q == LAST_CNT);

endmodule

// File: rtl/totp_sequencer.sv
// totp_sequencer: turns step-counter ticks / refresh requests into a BCD
// one-time code via the shared HMAC-SHA1 core and RFC 4226 truncation.
//   clk, rst      - clock, synchronous active-high reset
//   time_up       - pulse: step counter changed, current_time holds new T
//   current_time  - 64-bit step count T
//   refresh       - pulse: recompute code for current T
//   hmac_start    - pulse to HMAC core (high while in START)
//   hmac_msg      - big-endian T, stable from hmac_start to hmac_done
//   hmac_done     - pulse from HMAC core, hmac_digest valid that cycle
//   hmac_digest   - 160-bit SHA-1 output, byte 0 = bits [159:152]
//   code_bcd      - DIGITS BCD digits, digit 0 in bits [3:0]
//   code_valid    - pulse: code_bcd carries a new code this cycle
//   busy          - high whenever the FSM is not in IDLE
//   state_dbg     - current FSM state
//
// Handshake: hmac_start is a single-cycle request that the core must accept
// unconditionally; hmac_done is a single-cycle completion that is only
// honoured in HASH. code_valid is a single-cycle notification with no
// back-pressure; code_bcd holds its value until the next pulse.
module totp_sequencer
   import totp_pkg::*;
#(
   parameter int DIGITS = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   time_up,
   input  logic [MSG_W-1:0]       current_time,
   input  logic                   refresh,
   output logic                   hmac_start,
   output logic [MSG_W-1:0]       hmac_msg,
   input  logic                   hmac_done,
   input  logic [DIGEST_W-1:0]    hmac_digest,
   output logic [4*DIGITS-1:0]    code_bcd,
   output logic                   code_valid,
   output logic                   busy,
   output logic [2:0]             state_dbg
);

   localparam int CW = 4*DIGITS;

   totp_state_t          state_q, state_d;
   logic [MSG_W-1:0]     msg_q, msg_d;
   logic [MSG_W-1:0]     shadow_q, shadow_d;
   logic                 pend_q, pend_d;
   logic [TRUNC_W-1:0]   p_q, p_d;
   logic [CW-1:0]        code_q, code_d;

   logic                 req;
   logic [3:0]           offset;
   logic [TRUNC_W-1:0]   p_trunc;
   logic                 bcd_load;
   logic [4*BCD_DIGITS_MAX-1:0] bcd_full;
   logic                 bcd_done;
   logic                 unused_bits;

   assign req    = time_up | refresh;
   assign offset = hmac_digest[3:0];

   // Dynamic truncation: 31-bit window starting one bit below the MSB of
   // byte[offset], which drops the sign bit without a separate mask.
   always_comb begin
      p_trunc = '0;
      for (int i = 0; i < 16; i++) begin
         if (offset == 4'(i)) begin
            p_trunc = hmac_digest[DIGEST_W-2-8*i -: TRUNC_W];
         end
      end
   end

   // Only the offset nibble of the last digest byte is ever looked at, and
   // the top converter digits are dropped for DIGITS < 10.
   assign unused_bits = ^{hmac_digest[7:4], bcd_full[4*BCD_DIGITS_MAX-1:CW]};

   always_comb begin
      state_d    = state_q;
      msg_d      = msg_q;
      shadow_d   = shadow_q;
      pend_d     = pend_q;
      p_d        = p_q;
      code_d     = code_q;
      hmac_start = 1'b0;
      code_valid = 1'b0;
      bcd_load   = 1'b0;

      // Requests arriving while busy coalesce into one pending request that
      // uses the most recent T.
      if (state_q != ST_IDLE && req) begin
         pend_d   = 1'b1;
         shadow_d = current_time;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (req) begin
               msg_d   = current_time;
               state_d = ST_START;
            end
         end
         ST_START: begin
            hmac_start = 1'b1;
            state_d    = ST_HASH;
         end
         ST_HASH: begin
            if (hmac_done) begin
               p_d     = p_trunc;
               state_d = ST_TRUNC;
            end
         end
         ST_TRUNC: begin
            bcd_load = 1'b1;
            state_d  = ST_CONV;
         end
         ST_CONV: begin
            if (bcd_done) begin
               code_d  = bcd_full[CW-1:0];
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            code_valid = 1'b1;
            pend_d     = 1'b0;
            // A request landing in DONE itself is the newest one, so it
            // takes precedence over the shadowed value.
            if (req) begin
               msg_d   = current_time;
               state_d = ST_START;
            end else if (pend_q) begin
               msg_d   = shadow_q;
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         msg_q    <= '0;
         shadow_q <= '0;
         pend_q   <= 1'b0;
         p_q      <= '0;
         code_q   <= '0;
      end else begin
         state_q  <= state_d;
         msg_q    <= msg_d;
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
         p_q      <= p_d;
         code_q   <= code_d;
      end
   end

   bin2bcd_serial u_bcd (
      .clk  (clk),
      .rst  (rst),
      .load (bcd_load),
      .bin  (p_q),
      .bcd  (bcd_full),
      .done (bcd_done)
   );

   assign hmac_msg  = msg_q;
   assign code_bcd  = code_q;
   assign busy      = (state_q != ST_IDLE);
   assign state_dbg = state_q;

endmodule
